shared_reg_arbiter: RTL

Round-robin arbiter and write sequencer for a shared WIDTH-bit D-flip-flop register. Up to NREQ requesters compete to load the register; the block grants one requester at a time, captures its data on the grant cycle, then enforces a programmable cool-down before the next arbitration. It sits in front of any shared state register in the FSM datapath, replacing ad-hoc multi-driver loads of a plain `posedge clk` flip-flop.

---
 rtl/shared_reg_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter and write sequencer for one shared
// WIDTH-bit register. One requester is granted per slot, its data is captured
// at the end of the grant cycle, and a programmable cool-down follows.
module shared_reg_arbiter #(
  parameter  int WIDTH       = 8,
  parameter  int NREQ        = 4,
  parameter  int COOL_CYCLES = 1,
  localparam int IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  localparam logic [3:0]      COOL_LD  = 4'(COOL_CYCLES);
  localparam logic [IDX_W:0]  NREQ_W   = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       win_q;
  logic [3:0]             cnt_q;
  logic [NREQ-1:0]        gnt_q;
  logic [WIDTH-1:0]       q_q;
  logic                   q_valid_q;
  logic [IDX_W-1:0]       owner_q;

  logic [IDX_W-1:0]       win_d;
  logic                   any_req;
  logic [WIDTH-1:0]       wdata_arr [NREQ];

  // Unpack the flat write-data bus into one slice per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    logic [IDX_W:0] idx;
    any_req = 1'b0;
    win_d   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (!any_req && req[idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        win_d   = idx[IDX_W-1:0];
      end
    end
  end

  // Arbitration FSM with registered grant and shared-register outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gnt_q <= '0;
          if (any_req) begin
            win_q   <= win_d;
            gnt_q   <= ONE_HOT0 << win_d;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A requester that withdrew during its grant aborts the slot; the
          // pointer still advances so it cannot monopolise arbitration.
          if (req[win_q]) begin
            q_q       <= wdata_arr[win_q];
            owner_q   <= win_q;
            q_valid_q <= 1'b1;
          end
          ptr_q <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
          gnt_q <= '0;
          if (COOL_CYCLES == 0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= COOL_LD;
            state_q <= ST_COOL;
          end
        end
        ST_COOL: begin
          // Stay here for exactly COOL_LD cycles; requests are not observed.
          gnt_q <= '0;
          if (cnt_q <= 4'd1) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          gnt_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
